i2c_ctrl_master: RTL and testbench

//  Single-transfer I2C controller (master) that addresses the team's I2C minion over shared SCL/SDA.

---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_ctrl_master_qtick.sv | 60 ++++++
 rtl/i2c_ctrl_master.sv | 180 ++++++++++++++++++
 tb/tb_i2c_ctrl_master.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C controller master and its quarter-tick generator.
package i2c_pkg;

  localparam int DATA_W_DEF  = 6;
  localparam int ADDR_W_DEF  = 4;
  localparam int CLK_DIV_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    AACK,
    DATA,
    DACK,
    STOP
  } state_e;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_LOW  = 2'd0;
  localparam phase_t PH_RISE = 2'd1;
  localparam phase_t PH_HIGH = 2'd2;
  localparam phase_t PH_FALL = 2'd3;

endpackage

// File: rtl/i2c_ctrl_master_qtick.sv
// Quarter-period divider and bit-phase counter for the I2C master.
// Define I2C_STRETCH_EN to let a minion stretch SCL low during the rising quarter.
module i2c_qtick_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   run,
  input  logic   scl_in,
  output logic   q,
  output phase_t phase
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  phase_t           phase_q, phase_d;
  logic             hold;

`ifdef I2C_STRETCH_EN
  // The quarter restarts once SCL is really seen high, so the minion gets a full high quarter.
  assign hold = (phase_q == PH_RISE) && !scl_in;
`else
  logic unused_scl;
  assign unused_scl = scl_in;
  assign hold       = 1'b0;
`endif

  always_comb begin
    q       = run && !hold && (div_q == DIV_W'(CLK_DIV - 1));
    div_d   = div_q;
    phase_d = phase_q;
    if (!run) begin
      div_d   = '0;
      phase_d = PH_LOW;
    end else if (hold) begin
      div_d = '0;
    end else if (q) begin
      div_d   = '0;
      phase_d = phase_q + 2'd1;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      phase_q <= PH_LOW;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/i2c_ctrl_master.sv
// Single-transfer I2C master: START, address+R/W, ACK, data, ACK/NACK, STOP over open-drain SCL/SDA.
// Optional minion clock stretching is enabled by defining I2C_STRETCH_EN.
module i2c_ctrl_master
  import i2c_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              ack_err,
  input  logic              scl_in,
  output logic              scl_oe,
  input  logic              sda_in,
  output logic              sda_oe
);

  localparam int CNT_MAX = (ADDR_W + 1 > DATA_W) ? ADDR_W : DATA_W - 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W:0]   ashift_q, ashift_d;
  logic [DATA_W-1:0] dshift_q, dshift_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rw_q, rw_d;
  logic              smp_q, smp_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ack_err_q, ack_err_d;
  logic              scl_oe_q, scl_oe_d;
  logic              sda_oe_q, sda_oe_d;

  logic   q;
  phase_t phase;
  phase_t ph_next;
  logic   bit_end;

  i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (state_q != IDLE),
    .scl_in (scl_in),
    .q      (q),
    .phase  (phase)
  );

  assign ph_next = q ? phase + 2'd1 : phase;
  assign bit_end = q && (phase == PH_FALL);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ashift_d  = ashift_q;
    dshift_d  = dshift_q;
    rdata_d   = rdata_q;
    rw_d      = rw_q;
    smp_d     = smp_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;

    case (state_q)
      IDLE: if (start && !done_q) begin
        state_d   = START;
        rw_d      = rw;
        ashift_d  = {addr, rw};
        dshift_d  = wdata;
        ack_err_d = 1'b0;
        busy_d    = 1'b1;
      end
      START: if (bit_end) begin
        state_d = ADDR;
        cnt_d   = CNT_W'(ADDR_W);
      end
      ADDR: if (bit_end) begin
        ashift_d = {ashift_q[ADDR_W-1:0], 1'b0};
        if (cnt_q == '0) state_d = AACK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      AACK: if (bit_end) begin
        if (smp_q) begin
          ack_err_d = 1'b1;
          state_d   = STOP;
        end else begin
          state_d = DATA;
          cnt_d   = CNT_W'(DATA_W - 1);
        end
      end
      // The same register shifts write data out and read data in; only reads publish it.
      DATA: if (bit_end) begin
        dshift_d = {dshift_q[DATA_W-2:0], smp_q};
        if (cnt_q == '0) begin
          state_d = DACK;
          if (rw_q) rdata_d = {dshift_q[DATA_W-2:0], smp_q};
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DACK: if (bit_end) begin
        if (!rw_q && smp_q) ack_err_d = 1'b1;
        state_d = STOP;
      end
      STOP: if (bit_end) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (q && phase == PH_HIGH) smp_d = sda_in;

    // Line drive follows the upcoming state and phase so the pins stay registered.
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    case (state_d)
      START: begin
        sda_oe_d = 1'b1;
        scl_oe_d = (ph_next != PH_LOW);
      end
      ADDR, AACK, DATA, DACK: begin
        scl_oe_d = (ph_next == PH_LOW) || (ph_next == PH_FALL);
        if (state_d == ADDR) sda_oe_d = !ashift_d[ADDR_W];
        if (state_d == DATA) sda_oe_d = !rw_d && !dshift_d[DATA_W-1];
      end
      STOP: begin
        scl_oe_d = (ph_next == PH_LOW);
        sda_oe_d = (ph_next == PH_LOW) || (ph_next == PH_RISE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ashift_q  <= '0;
      dshift_q  <= '0;
      rdata_q   <= '0;
      rw_q      <= 1'b0;
      smp_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ashift_q  <= ashift_d;
      dshift_q  <= dshift_d;
      rdata_q   <= rdata_d;
      rw_q      <= rw_d;
      smp_q     <= smp_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign scl_oe  = scl_oe_q;
  assign sda_oe  = sda_oe_q;

endmodule

// File: tb/tb_i2c_ctrl_master.sv
// Bench for i2c_ctrl_master: a bus-level minion at address 4'b0010 on a wired-AND bus,
// a frame-level expectation model, and a per-cycle busy/done comparison.
module tb_i2c_ctrl_master;

  localparam int AW = 4;
  localparam int DW = 6;
  localparam int CD = 4;
  localparam int LFULL = (AW + DW + 5) * 4 * CD;
  localparam int LNACK = (AW + 4) * 4 * CD;
  localparam logic [AW-1:0] MINION_ADDR = 4'b0010;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          rw = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          busy, done, ack_err, scl_oe, sda_oe;

  logic scl_hold = 1'b0;
  logic sda_low  = 1'b0;
  wire  scl_line = !(scl_oe || scl_hold);
  wire  sda_line = !(sda_oe || sda_low);

  i2c_ctrl_master #(.DATA_W(DW), .ADDR_W(AW), .CLK_DIV(CD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .rw      (rw),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .scl_in  (scl_line),
    .scl_oe  (scl_oe),
    .sda_in  (sda_line),
    .sda_oe  (sda_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int fails   = 0;
  int cyc_prints = 0;

  // Frame model: what the current frame must look like, from the transfer fields alone.
  int            mode = 0;
  int            exp_s = 0;
  int            exp_l = 0;
  logic          e_rw, e_dn, e_match;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_w, e_rd;
  logic [DW-1:0] model_rdata = '0;
  int            last_lat = 0;
  logic [AW:0]   last_abits;
  logic [DW-1:0] last_dbits;
  logic          chk_en = 1'b0;

  // Minion state, sampled on the falling clock so bus edges have settled.
  logic          m_active = 1'b0, m_match = 1'b0, m_rw = 1'b0;
  logic          m_bits [0:15];
  int            m_rises = 0, m_falls = 0;
  logic [DW-1:0] m_rd = '0;
  logic          m_dnack = 1'b0;
  logic          prev_scl = 1'b1, prev_sda = 1'b1, prev_scl_oe = 1'b0;
  logic          st_en = 1'b0;
  int            st_rel = 0, st_cnt = 0;

  always @(negedge clk) begin : minion
    logic sl, dl;
    int nb;
    if (!rst_n) begin
      m_active = 1'b0; m_match = 1'b0; sda_low = 1'b0; scl_hold = 1'b0;
      st_cnt = 0; st_rel = 0; prev_scl = 1'b1; prev_sda = 1'b1; prev_scl_oe = 1'b0;
    end else begin
      if (st_cnt > 0) begin
        st_cnt--;
        if (st_cnt == 0) scl_hold = 1'b0;
      end
      if (st_en && m_active && prev_scl_oe && !scl_oe) begin
        st_rel++;
        if (st_rel == 4) begin scl_hold = 1'b1; st_cnt = 20; end
      end
      sl = !(scl_oe || scl_hold);
      dl = !(sda_oe || sda_low);
      if (sl && prev_scl && prev_sda && !dl) begin
        m_active = 1'b1; m_match = 1'b0; m_rises = 0; m_falls = 0; st_rel = 0; sda_low = 1'b0;
      end else if (sl && prev_scl && !prev_sda && dl) begin
        m_active = 1'b0; sda_low = 1'b0;
      end else if (m_active) begin
        if (sl && !prev_scl) begin
          if (m_rises < 16) m_bits[m_rises] = dl;
          m_rises++;
        end
        if (!sl && prev_scl) begin
          m_falls++;
          nb = m_falls - 1;
          sda_low = 1'b0;
          if (nb == 5) begin
            m_match = ({m_bits[0], m_bits[1], m_bits[2], m_bits[3]} == MINION_ADDR);
            m_rw    = m_bits[4];
            sda_low = m_match;
          end else if (nb >= 6 && nb <= 11 && m_match && m_rw) begin
            sda_low = !m_rd[DW-1-(nb-6)];
          end else if (nb == 12 && m_match && !m_rw) begin
            sda_low = !m_dnack;
          end
        end
      end
      prev_scl    = sl;
      prev_sda    = !(sda_oe || sda_low);
      prev_scl_oe = scl_oe;
    end
  end

  // Every cycle: busy must cover exactly the frame window and done must pulse once at its end.
  always @(negedge clk) begin : cycle_compare
    logic eb, ed;
    if (chk_en && mode != 2) begin
      eb = (mode == 1) && (cyc >= exp_s) && (cyc < exp_s + exp_l);
      ed = (mode == 1) && (cyc == exp_s + exp_l);
      vectors++;
      if (busy !== eb || done !== ed) begin
        fails++;
        if (cyc_prints < 20) begin
          cyc_prints++;
          $display("[TB] FAIL cycle_busy_done cyc=%0d got busy=%b done=%b want busy=%b done=%b",
                   cyc, busy, done, eb, ed);
        end
      end
    end
  end

  task automatic checkOutput(input string nm, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [AW-1:0] a, input logic [DW-1:0] w,
                               input logic [DW-1:0] rd, input logic dn, input int md);
    @(posedge clk); #1;
    e_rw = r; e_addr = a; e_w = w; e_rd = rd; e_dn = dn;
    e_match = (a == MINION_ADDR);
    exp_l   = e_match ? LFULL : LNACK;
    m_rd = rd; m_dnack = dn;
    start = 1'b1; rw = r; addr = a; wdata = w;
    exp_s = cyc + 1;
    mode  = md;
    @(posedge clk); #1;
    start = 1'b0;
    rw    = 1'($urandom);
    addr  = AW'($urandom);
    wdata = DW'($urandom);
  endtask

  task automatic finishFrame(input int extra_lo, input int extra_hi);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 3000);
    if (done !== 1'b1) begin
      vectors++; fails++;
      $display("[TB] FAIL frame_timeout got=no_done want=done within 3000 cycles");
    end else begin
      last_lat = cyc - exp_s;
      if (extra_hi == 0) begin
        checkOutput("latency", last_lat, exp_l);
      end else begin
        vectors++;
        if (last_lat < exp_l + extra_lo || last_lat > exp_l + extra_hi) begin
          fails++;
          $display("[TB] FAIL stretch_latency got=%0d want=%0d..%0d", last_lat,
                   exp_l + extra_lo, exp_l + extra_hi);
        end
      end
      if (e_match && e_rw) model_rdata = e_rd;
      for (int i = 0; i <= AW; i++) last_abits[AW-i] = m_bits[i];
      for (int i = 0; i < DW; i++) last_dbits[DW-1-i] = m_bits[6+i];
      checkOutput("ack_err", ack_err, !e_match || (!e_rw && e_dn));
      checkOutput("rdata", rdata, model_rdata);
      checkOutput("busy_at_done", busy, 0);
      checkOutput("addr_bits", last_abits, {e_addr, e_rw});
      checkOutput("aack_bit", m_bits[5], !e_match);
      checkOutput("scl_rises", m_rises, e_match ? 14 : 7);
      if (e_match) begin
        checkOutput("data_bits", last_dbits, e_rw ? e_rd : e_w);
        checkOutput("dack_bit", m_bits[12], e_rw ? 1'b1 : e_dn);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_scl_oe", scl_oe, 0);
    checkOutput("reset_sda_oe", sda_oe, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_ack_err", ack_err, 0);
    checkOutput("reset_rdata", rdata, 0);
    rst_n  = 1'b1;
    mode   = 0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);

    $display("[TB] write to minion");
    applyStimulus(1'b0, 4'b0010, 6'b101101, 6'b000000, 1'b0, 1);
    finishFrame(0, 0);
    checkOutput("lit_write_addr_bits", last_abits, 5'b00100);
    checkOutput("lit_write_data_bits", last_dbits, 6'b101101);
    checkOutput("lit_write_latency", last_lat, 240);
    checkOutput("lit_write_ack_err", ack_err, 0);

    $display("[TB] write to absent address");
    applyStimulus(1'b0, 4'b0111, 6'b101010, 6'b000000, 1'b0, 1);
    finishFrame(0, 0);
    checkOutput("lit_nack_latency", last_lat, 128);
    checkOutput("lit_nack_ack_err", ack_err, 1);
    checkOutput("lit_nack_rises", m_rises, 7);

    $display("[TB] read from minion");
    applyStimulus(1'b1, 4'b0010, 6'b000000, 6'b110011, 1'b0, 1);
    finishFrame(0, 0);
    checkOutput("lit_read_rdata", rdata, 6'b110011);
    checkOutput("lit_read_master_nack", m_bits[12], 1);

    $display("[TB] start while busy");
    applyStimulus(1'b0, 4'b0010, 6'b011001, 6'b000000, 1'b0, 1);
    repeat (49) @(posedge clk);
    #1;
    start = 1'b1; rw = 1'b1; addr = 4'b0111; wdata = 6'b111111;
    @(posedge clk); #1;
    start = 1'b0;
    finishFrame(0, 0);

    $display("[TB] start during done");
    start = 1'b1; rw = 1'b0; addr = 4'b0010; wdata = 6'b000111;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("start_on_done_ignored", busy, 0);

    $display("[TB] random frames");
    for (int k = 0; k < 20; k++) begin
      logic          r, dn;
      logic [AW-1:0] a;
      r  = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 2) == 0) ? AW'($urandom) : MINION_ADDR;
      dn = ($urandom_range(0, 3) == 0);
      applyStimulus(r, a, DW'($urandom), DW'($urandom), dn, 1);
      finishFrame(0, 0);
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end

    $display("[TB] reset mid-data");
    applyStimulus(1'b0, 4'b0010, 6'b000000, 6'b000000, 1'b0, 1);
    repeat (130) @(posedge clk);
    #1;
    checkOutput("pre_reset_scl_oe", scl_oe, 1);
    checkOutput("pre_reset_sda_oe", sda_oe, 1);
    mode  = 0;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_scl_oe", scl_oe, 0);
    checkOutput("midreset_sda_oe", sda_oe, 0);
    checkOutput("midreset_busy", busy, 0);
    model_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'b0010, 6'b000000, 6'b100110, 1'b0, 1);
    finishFrame(0, 0);

`ifdef I2C_STRETCH_EN
    $display("[TB] clock stretch on bit 3");
    st_en = 1'b1;
    applyStimulus(1'b0, 4'b0010, 6'b110100, 6'b000000, 1'b0, 2);
    finishFrame(20, 20 + CD);
    st_en = 1'b0;
    mode  = 0;
`endif

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
